// File: rtl/lsu_dmem_resp_pkg.sv
// ---------------------------------------------------------------------------
// lsu_dmem_resp_pkg
//   Shared types for the LSU data-memory responder. Contents:
//     iq_lsu_pkg_t   - request from the issue queue
//     exc_info_t     - execute-stage exception information
//     lsu_iq_pkg_t   - response to the issue queue
//     decode_info_t  - decode info carried alongside a request
//     lsu_state_e    - responder state encoding
//   Also holds the ALE exception code, the msize encodings, reset values and
//   small helpers for the alignment and read-mask rules.
// ---------------------------------------------------------------------------
package lsu_dmem_resp_pkg;

    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic [1:0] MSIZE_BYTE = 2'd0;
    localparam logic [1:0] MSIZE_HALF = 2'd1;
    localparam logic [1:0] MSIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] wdata;      // already shifted into its byte lanes
        logic [3:0]  strb;       // 0 for loads
        logic [3:0]  rmask;
        logic [1:0]  msize;
        logic        msigned;
        logic [3:0]  wid;
        logic [4:0]  cache_code;
        logic        is_cacop;
    } iq_lsu_pkg_t;

    typedef struct packed {
        logic        execute_exception;
        logic [5:0]  exc_code;
        logic [31:0] badv;
    } exc_info_t;

    typedef struct packed {
        logic [31:0] rdata;
        exc_info_t   execute_exc_info;
    } lsu_iq_pkg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb_en;
        logic [7:0]  uop;
    } decode_info_t;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_RESP  = 3'd3,
        LSU_DRAIN = 3'd4
    } lsu_state_e;

    localparam exc_info_t EXC_INFO_NULL = '{
        execute_exception: 1'b0,
        exc_code:          6'h00,
        badv:              32'h0000_0000
    };

    localparam lsu_iq_pkg_t LSU_IQ_RESP_NULL = '{
        rdata:            32'h0000_0000,
        execute_exc_info: EXC_INFO_NULL
    };

    localparam decode_info_t DECODE_INFO_NULL = '{
        pc:    32'h0000_0000,
        rd:    5'd0,
        wb_en: 1'b0,
        uop:   8'h00
    };

    // Half-words need an even address, words a word-aligned address.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] msize);
        logic mis;
        case (msize)
            MSIZE_HALF: mis = off[0];
            MSIZE_WORD: mis = (off != 2'b00);
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte lanes an aligned load of this size touches.
    function automatic logic [3:0] load_rmask(input logic [1:0] off, input logic [1:0] msize);
        logic [3:0] m;
        case (msize)
            MSIZE_BYTE: m = 4'b0001 << off;
            MSIZE_HALF: m = 4'b0011 << off;
            MSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_dmem_resp_chk.sv
// ---------------------------------------------------------------------------
// lsu_dmem_resp_chk
//   Simulation-only protocol checker for lsu_dmem_resp. Produces no outputs.
//   Checks: memory responses only while one is outstanding, memory request
//   held stable while stalled, rmask consistent with size/offset for aligned
//   loads, and a watchdog bounding time spent waiting on memory.
// Parameters
//   MEM_LAT_MAX  longest legal stay in WAIT/DRAIN, in cycles
// ---------------------------------------------------------------------------
module lsu_dmem_resp_chk
    import lsu_dmem_resp_pkg::*;
#(
    parameter int unsigned MEM_LAT_MAX = 32'd16
) (
    input logic        clk,
    input logic        rst_n,
    input logic        flush,
    input lsu_state_e  state,
    input logic        accept,
    input logic [1:0]  req_off,
    input logic [1:0]  req_msize,
    input logic [3:0]  req_strb,
    input logic [3:0]  req_rmask,
    input logic        req_is_cacop,
    input logic        mem_req_valid,
    input logic        mem_req_ready,
    input logic [31:0] mem_addr,
    input logic [3:0]  mem_strb,
    input logic [31:0] mem_wdata,
    input logic        mem_resp_valid
);

    int unsigned lat_cnt_r;
    logic        rmask_checked_s;
    logic        rmask_ok_s;

    // Count consecutive cycles spent waiting on the memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt_r <= 32'd0;
        end else if (state == LSU_WAIT || state == LSU_DRAIN) begin
            lat_cnt_r <= lat_cnt_r + 32'd1;
        end else begin
            lat_cnt_r <= 32'd0;
        end
    end

    // rmask is only meaningful for aligned, non-cacop loads.
    always_comb begin
        rmask_checked_s = 1'b0;
        rmask_ok_s      = 1'b1;
        if (accept && req_strb == 4'h0 && !req_is_cacop && !is_misaligned(req_off, req_msize)) begin
            rmask_checked_s = 1'b1;
            rmask_ok_s      = (req_rmask == load_rmask(req_off, req_msize));
        end else begin
            rmask_checked_s = 1'b0;
            rmask_ok_s      = 1'b1;
        end
    end

    a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_valid |-> (state == LSU_WAIT || state == LSU_DRAIN));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_valid && !mem_req_ready && !flush) |=>
            (mem_req_valid && $stable(mem_addr) && $stable(mem_strb) && $stable(mem_wdata)));

    a_rmask_match: assert property (@(posedge clk) disable iff (!rst_n)
        rmask_checked_s |-> rmask_ok_s);

    a_mem_watchdog: assert property (@(posedge clk) disable iff (!rst_n)
        lat_cnt_r <= MEM_LAT_MAX);

endmodule

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
//   Combinational load formatter: moves the addressed byte lane of the raw
//   memory word down to bit 0, then zero- or sign-extends a byte, half-word or
//   word to 32 bits.
// Ports
//   rdata_raw  in  32  raw word from memory
//   byte_off   in  2   vaddr[1:0] of the load
//   msize      in  2   0 byte, 1 half, 2 word
//   msigned    in  1   sign-extend when set
//   rdata      out 32  formatted load data
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_dmem_resp_pkg::*;
(
    input  logic [31:0] rdata_raw,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  msize,
    input  logic        msigned,
    output logic [31:0] rdata
);

    logic [31:0] shifted_s;
    logic        sign_s;

    assign shifted_s = rdata_raw >> {byte_off, 3'b000};

    // Size selection and extension of the lane-aligned word.
    always_comb begin
        rdata  = shifted_s;
        sign_s = 1'b0;
        case (msize)
            MSIZE_BYTE: begin
                sign_s = msigned & shifted_s[7];
                rdata  = {{24{sign_s}}, shifted_s[7:0]};
            end
            MSIZE_HALF: begin
                sign_s = msigned & shifted_s[15];
                rdata  = {{16{sign_s}}, shifted_s[15:0]};
            end
            MSIZE_WORD: begin
                rdata  = shifted_s;
            end
            default: begin
                rdata  = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_resp.sv
// ---------------------------------------------------------------------------
// lsu_dmem_resp
//   Responder for the IQ->LSU request / LSU->IQ response handshake. Accepts
//   one load/store at a time, optionally checks alignment, performs a single
//   word access on the data-memory port, formats load data and returns the
//   response together with the request's decode info. vaddr is used as paddr.
//
//   Build option LSU_ALE_CHECK_EN: when defined, misaligned half/word accesses
//   raise ECODE_ALE with badv = vaddr and never reach memory. When undefined,
//   no alignment check is made and the exception fields are always zero.
//
// Parameters
//   MEM_LAT_MAX       watchdog bound for WAIT/DRAIN (checker only)
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   flush             pipeline flush (abandons the current request)
//   iq_lsu_valid_i / iq_lsu_ready_o / iq_lsu_req_i / iq_lsu_di_i
//                     request channel; ready only in IDLE
//   lsu_iq_valid_o / lsu_iq_ready_i / lsu_iq_resp_o / lsu_iq_di_o
//                     response channel
//   mem_req_valid_o / mem_req_ready_i / mem_addr_o / mem_strb_o / mem_wdata_o
//                     memory request; strb 0 means read
//   mem_resp_valid_i / mem_rdata_i
//                     one response per accepted memory request
// ---------------------------------------------------------------------------
module lsu_dmem_resp
    import lsu_dmem_resp_pkg::*;
#(
    parameter int unsigned MEM_LAT_MAX = 32'd16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         iq_lsu_valid_i,
    output logic         iq_lsu_ready_o,
    input  iq_lsu_pkg_t  iq_lsu_req_i,
    input  decode_info_t iq_lsu_di_i,
    output logic         lsu_iq_valid_o,
    input  logic         lsu_iq_ready_i,
    output lsu_iq_pkg_t  lsu_iq_resp_o,
    output decode_info_t lsu_iq_di_o,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic [31:0]  mem_addr_o,
    output logic [3:0]   mem_strb_o,
    output logic [31:0]  mem_wdata_o,
    input  logic         mem_resp_valid_i,
    input  logic [31:0]  mem_rdata_i
);

    lsu_state_e   state_r;
    lsu_state_e   state_nxt_s;

    logic         accept_s;
    logic         ale_s;
    logic         bypass_s;
    exc_info_t    exc_nxt_s;

    logic [1:0]   byte_off_r;
    logic [1:0]   msize_r;
    logic         msigned_r;
    logic [31:0]  mem_addr_r;
    logic [3:0]   mem_strb_r;
    logic [31:0]  mem_wdata_r;
    lsu_iq_pkg_t  resp_r;
    decode_info_t di_r;
    logic [31:0]  rdata_fmt_s;

    // wid and cache_code ride along for other consumers; nothing here uses them.
    logic         unused_req_fields_s;
    assign unused_req_fields_s = ^{iq_lsu_req_i.wid, iq_lsu_req_i.cache_code};

    assign accept_s = iq_lsu_valid_i & iq_lsu_ready_o;

`ifdef LSU_ALE_CHECK_EN
    // cacop never faults, even with a misaligned vaddr.
    assign ale_s = is_misaligned(iq_lsu_req_i.vaddr[1:0], iq_lsu_req_i.msize) & ~iq_lsu_req_i.is_cacop;
`else
    assign ale_s = 1'b0;
`endif

    // Faulting requests and cacops are answered without touching memory.
    assign bypass_s = ale_s | iq_lsu_req_i.is_cacop;

    // Exception fields captured with the request.
    always_comb begin
        exc_nxt_s = EXC_INFO_NULL;
        if (ale_s) begin
            exc_nxt_s.execute_exception = 1'b1;
            exc_nxt_s.exc_code          = ECODE_ALE;
            exc_nxt_s.badv              = iq_lsu_req_i.vaddr;
        end else begin
            exc_nxt_s = EXC_INFO_NULL;
        end
    end

    lsu_load_align u_load_align (
        .rdata_raw (mem_rdata_i),
        .byte_off  (byte_off_r),
        .msize     (msize_r),
        .msigned   (msigned_r),
        .rdata     (rdata_fmt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush abandons the request but a memory response
    // already owed must still be absorbed in DRAIN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (flush) begin
                    state_nxt_s = LSU_IDLE;
                end else if (iq_lsu_valid_i) begin
                    state_nxt_s = bypass_s ? LSU_RESP : LSU_REQ;
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (flush) begin
                    state_nxt_s = mem_req_ready_i ? LSU_DRAIN : LSU_IDLE;
                end else begin
                    state_nxt_s = mem_req_ready_i ? LSU_WAIT : LSU_REQ;
                end
            end
            LSU_WAIT: begin
                if (flush) begin
                    state_nxt_s = mem_resp_valid_i ? LSU_IDLE : LSU_DRAIN;
                end else begin
                    state_nxt_s = mem_resp_valid_i ? LSU_RESP : LSU_WAIT;
                end
            end
            LSU_RESP: begin
                if (flush || lsu_iq_ready_i) begin
                    state_nxt_s = LSU_IDLE;
                end else begin
                    state_nxt_s = LSU_RESP;
                end
            end
            LSU_DRAIN: begin
                // The owed response ends DRAIN whether or not flush is high.
                if (mem_resp_valid_i) begin
                    state_nxt_s = LSU_IDLE;
                end else begin
                    state_nxt_s = LSU_DRAIN;
                end
            end
            default: begin
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        iq_lsu_ready_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        lsu_iq_valid_o  = 1'b0;
        case (state_r)
            LSU_IDLE: iq_lsu_ready_o  = 1'b1;
            LSU_REQ:  mem_req_valid_o = 1'b1;
            LSU_RESP: lsu_iq_valid_o  = 1'b1;
            default: begin
                iq_lsu_ready_o  = 1'b0;
                mem_req_valid_o = 1'b0;
                lsu_iq_valid_o  = 1'b0;
            end
        endcase
    end

    // Request capture, load data write-back and response register.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            byte_off_r  <= 2'b00;
            msize_r     <= 2'b00;
            msigned_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_strb_r  <= 4'h0;
            mem_wdata_r <= 32'h0000_0000;
            resp_r      <= LSU_IQ_RESP_NULL;
            di_r        <= DECODE_INFO_NULL;
        end else if (accept_s) begin
            byte_off_r              <= iq_lsu_req_i.vaddr[1:0];
            msize_r                 <= iq_lsu_req_i.msize;
            msigned_r               <= iq_lsu_req_i.msigned;
            mem_addr_r              <= {iq_lsu_req_i.vaddr[31:2], 2'b00};
            mem_strb_r              <= iq_lsu_req_i.strb;
            mem_wdata_r             <= iq_lsu_req_i.wdata;
            resp_r.rdata            <= 32'h0000_0000;
            resp_r.execute_exc_info <= exc_nxt_s;
            di_r                    <= iq_lsu_di_i;
        end else if (state_r == LSU_WAIT && mem_resp_valid_i) begin
            // A store's ack carries no load data.
            resp_r.rdata <= (mem_strb_r != 4'h0) ? 32'h0000_0000 : rdata_fmt_s;
        end
    end

    assign mem_addr_o    = mem_addr_r;
    assign mem_strb_o    = mem_strb_r;
    assign mem_wdata_o   = mem_wdata_r;
    assign lsu_iq_resp_o = resp_r;
    assign lsu_iq_di_o   = di_r;

    lsu_dmem_resp_chk #(
        .MEM_LAT_MAX (MEM_LAT_MAX)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .state          (state_r),
        .accept         (accept_s),
        .req_off        (iq_lsu_req_i.vaddr[1:0]),
        .req_msize      (iq_lsu_req_i.msize),
        .req_strb       (iq_lsu_req_i.strb),
        .req_rmask      (iq_lsu_req_i.rmask),
        .req_is_cacop   (iq_lsu_req_i.is_cacop),
        .mem_req_valid  (mem_req_valid_o),
        .mem_req_ready  (mem_req_ready_i),
        .mem_addr       (mem_addr_o),
        .mem_strb       (mem_strb_o),
        .mem_wdata      (mem_wdata_o),
        .mem_resp_valid (mem_resp_valid_i)
    );

endmodule
